// File: rtl/ip_checksum_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ip_checksum_arbiter
// Brief    : Two-requester arbiter sharing one IP header checksum calculator;
//            sequences IDLE/CALC/WAIT/DONE and owns the IP identification counter.
// Revision : 1.0 - initial release
// ============================================================================
module ip_checksum_arbiter #(
    parameter logic [15:0] ID_INIT   = 16'h0000,
    parameter int          FIXED_PRI = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] len0,
    input  logic [15:0] len1,
    output logic        cal_en,
    output logic [15:0] ip_total_len,
    output logic [15:0] ip_id,
    input  logic [15:0] chk_in,
    output logic [1:0]  gnt,
    output logic        done0,
    output logic        done1,
    output logic [15:0] hdr_checksum,
    output logic [15:0] hdr_id,
    output logic        busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  r_gnt;
    logic        r_last;      // 1 = requester 1 served most recently
    logic [15:0] r_ip_id;
    logic [15:0] r_hdr_chk;
    logic [15:0] r_hdr_id;

    logic        w_tie;
    logic        w_pick1;
    logic [1:0]  w_win;

    // On a tie, round-robin hands the grant to whoever was not served last.
    always_comb begin
        w_tie   = req0 & req1;
        w_pick1 = 1'b0;
        if (w_tie) begin
            w_pick1 = (FIXED_PRI != 0) ? 1'b0 : ~r_last;
        end else begin
            w_pick1 = req1;
        end
        w_win = w_pick1 ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_gnt     <= 2'b00;
            r_last    <= 1'b0;
            r_ip_id   <= ID_INIT;
            r_hdr_chk <= 16'h0000;
            r_hdr_id  <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req0 | req1) begin
                        r_gnt   <= w_win;
                        r_last  <= w_pick1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_hdr_chk <= chk_in;
                    r_hdr_id  <= r_ip_id;
                    r_state   <= S_DONE;
                end
                S_DONE: begin
                    r_ip_id <= r_ip_id + 16'd1;
                    r_gnt   <= 2'b00;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt   <= 2'b00;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cal_en       = (r_state == S_CALC);
        busy         = (r_state != S_IDLE);
        done0        = (r_state == S_DONE) & r_gnt[0];
        done1        = (r_state == S_DONE) & r_gnt[1];
        gnt          = r_gnt;
        ip_id        = r_ip_id;
        hdr_checksum = r_hdr_chk;
        hdr_id       = r_hdr_id;
        ip_total_len = 16'h0000;
        if (r_gnt[1]) begin
            ip_total_len = len1;
        end else if (r_gnt[0]) begin
            ip_total_len = len0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ip_checksum_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ip_checksum_arbiter
// Brief    : Self-checking bench; DUT 0 is round-robin with ID_INIT=0,
//            DUT 1 is fixed-priority with ID_INIT=16'hFFFF.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ip_checksum_arbiter;

    typedef struct {
        logic [1:0]  g;
        logic [15:0] len;
        logic [15:0] chk;
        logic [15:0] id;
    } exp_t;

    typedef struct {
        bit          pre_rst;
        logic        r0;
        logic        r1;
        logic [15:0] l0;
        logic [15:0] l1;
        logic [15:0] c;
        logic [1:0]  eg;
        bit          hold;
    } vec_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic        rq0 [2];
    logic        rq1 [2];
    logic [15:0] ln0 [2];
    logic [15:0] ln1 [2];
    logic [15:0] chk [2];
    logic        cal_en [2];
    logic [15:0] tlen [2];
    logic [15:0] ipid [2];
    logic [1:0]  gnt [2];
    logic        dn0 [2];
    logic        dn1 [2];
    logic [15:0] hchk [2];
    logic [15:0] hid [2];
    logic        busy [2];

    int total = 0;
    int bad   = 0;

    exp_t sq0[$];
    exp_t sq1[$];
    logic [15:0] m_id  [2];
    logic [15:0] m_hdr [2];
    logic [15:0] m_hid [2];

    for (genvar i = 0; i < 2; i++) begin : g_dut
        ip_checksum_arbiter #(
            .ID_INIT   ((i == 0) ? 16'h0000 : 16'hFFFF),
            .FIXED_PRI (i)
        ) u_dut (
            .clk          (clk),
            .reset        (rst[i]),
            .req0         (rq0[i]),
            .req1         (rq1[i]),
            .len0         (ln0[i]),
            .len1         (ln1[i]),
            .cal_en       (cal_en[i]),
            .ip_total_len (tlen[i]),
            .ip_id        (ipid[i]),
            .chk_in       (chk[i]),
            .gnt          (gnt[i]),
            .done0        (dn0[i]),
            .done1        (dn1[i]),
            .hdr_checksum (hchk[i]),
            .hdr_id       (hid[i]),
            .busy         (busy[i])
        );
    end

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        chk16(nm, {15'd0, act}, {15'd0, exp});
    endtask

    // Scoreboards: one expected record per grant, popped on each done pulse.
    exp_t e0, e1;
    always @(negedge clk) begin
        if (dn0[0] | dn1[0]) begin
            if (sq0.size() == 0) begin
                total++; bad++;
                $display("FAIL d0_unexpected_done: got done=%b%b want none", dn1[0], dn0[0]);
            end else begin
                e0 = sq0.pop_front();
                chk16("d0_done_bits", {14'd0, dn1[0], dn0[0]}, {14'd0, e0.g});
                chk16("d0_hdr_checksum", hchk[0], e0.chk);
                chk16("d0_hdr_id", hid[0], e0.id);
            end
        end
    end

    always @(negedge clk) begin
        if (dn0[1] | dn1[1]) begin
            if (sq1.size() == 0) begin
                total++; bad++;
                $display("FAIL d1_unexpected_done: got done=%b%b want none", dn1[1], dn0[1]);
            end else begin
                e1 = sq1.pop_front();
                chk16("d1_done_bits", {14'd0, dn1[1], dn0[1]}, {14'd0, e1.g});
                chk16("d1_hdr_checksum", hchk[1], e1.chk);
                chk16("d1_hdr_id", hid[1], e1.id);
            end
        end
    end

    // Protocol guard: len1 must not move while requester 1 holds the grant.
    logic [15:0] g1len = 16'h0000;
    always @(negedge clk) begin
        if (cal_en[0] && gnt[0] == 2'b10) begin
            g1len <= ln1[0];
        end else if (busy[0] && gnt[0] == 2'b10 && ln1[0] !== g1len) begin
            bad++;
            $display("FAIL len1_stable: got %h want %h", ln1[0], g1len);
        end
    end

    // Starts at the falling edge of an IDLE cycle, returns at the next IDLE one.
    task automatic txn(input int d, input logic r0, input logic r1,
                       input logic [15:0] l0, input logic [15:0] l1, input logic [15:0] c,
                       input logic [1:0] eg, input bit hold);
        exp_t e;
        logic [15:0] el;
        el = eg[1] ? l1 : l0;
        chkb("idle_busy", busy[d], 1'b0);
        chk16("idle_gnt", {14'd0, gnt[d]}, 16'd0);
        chk16("idle_len", tlen[d], 16'h0000);
        rq0[d] = r0; rq1[d] = r1; ln0[d] = l0; ln1[d] = l1; chk[d] = ~c;
        e.g = eg; e.len = el; e.chk = c; e.id = m_id[d];
        if (d == 0) sq0.push_back(e); else sq1.push_back(e);
        @(negedge clk);
        chkb("calc_cal_en", cal_en[d], 1'b1);
        chk16("calc_gnt", {14'd0, gnt[d]}, {14'd0, eg});
        chk16("calc_len", tlen[d], el);
        chk16("calc_hdr_hold", hchk[d], m_hdr[d]);
        chk16("calc_hid_hold", hid[d], m_hid[d]);
        @(negedge clk);
        chk[d] = c;
        chkb("wait_cal_en", cal_en[d], 1'b0);
        chk16("wait_gnt", {14'd0, gnt[d]}, {14'd0, eg});
        chk16("wait_hdr_hold", hchk[d], m_hdr[d]);
        @(negedge clk);
        chk[d] = ~c;
        chk16("done_gnt", {14'd0, gnt[d]}, {14'd0, eg});
        m_hdr[d] = c; m_hid[d] = m_id[d]; m_id[d] = m_id[d] + 16'd1;
        if (!hold) begin
            rq0[d] = 1'b0; rq1[d] = 1'b0;
        end
        @(negedge clk);
        chk16("ip_id_after", ipid[d], m_id[d]);
    endtask

    task automatic model_reset(input int d);
        m_id[d]  = (d == 0) ? 16'h0000 : 16'hFFFF;
        m_hdr[d] = 16'h0000;
        m_hid[d] = 16'h0000;
    endtask

    vec_t vt[8];
    exp_t eg0;

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{1'b0, 1'b1, 1'b0, 16'h002E, 16'h0000, 16'hB1E6, 2'b01, 1'b0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 16'h0100, 16'h0200, 16'h1111, 2'b10, 1'b1};
        vt[2] = '{1'b0, 1'b1, 1'b1, 16'h0100, 16'h0200, 16'h2222, 2'b01, 1'b1};
        vt[3] = '{1'b0, 1'b1, 1'b1, 16'h0100, 16'h0200, 16'h3333, 2'b10, 1'b1};
        vt[4] = '{1'b0, 1'b1, 1'b1, 16'h0100, 16'h0200, 16'h4444, 2'b01, 1'b0};
        vt[5] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h05DC, 16'hABCD, 2'b10, 1'b0};
        vt[6] = '{1'b0, 1'b1, 1'b1, 16'h0040, 16'h0050, 16'h0F0F, 2'b01, 1'b0};
        vt[7] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 2'b01, 1'b0};

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; rq0[d] = 1'b0; rq1[d] = 1'b0;
            ln0[d] = 16'h0; ln1[d] = 16'h0; chk[d] = 16'h0;
            model_reset(d);
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0;
            chkb("rst_busy", busy[d], 1'b0);
            chkb("rst_cal_en", cal_en[d], 1'b0);
            chk16("rst_gnt", {14'd0, gnt[d]}, 16'd0);
            chk16("rst_done", {14'd0, dn1[d], dn0[d]}, 16'd0);
            chk16("rst_hdr_checksum", hchk[d], 16'h0000);
            chk16("rst_hdr_id", hid[d], 16'h0000);
            chk16("rst_ip_id", ipid[d], m_id[d]);
        end

        // Round-robin DUT: table of transactions.
        for (int i = 0; i < 8; i++) begin
            if (vt[i].pre_rst) begin
                rst[0] = 1'b1;
                @(negedge clk);
                rst[0] = 1'b0;
                model_reset(0);
            end
            txn(0, vt[i].r0, vt[i].r1, vt[i].l0, vt[i].l1, vt[i].c, vt[i].eg, vt[i].hold);
        end

        // Reset during WAIT of a requester-1 grant aborts it.
        rq1[0] = 1'b1; ln1[0] = 16'h0777; chk[0] = 16'h9999;
        @(negedge clk);
        chk16("abort_gnt", {14'd0, gnt[0]}, 16'd2);
        @(negedge clk);
        rst[0] = 1'b1; rq1[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b0;
        model_reset(0);
        chkb("abort_busy", busy[0], 1'b0);
        chk16("abort_gnt_clr", {14'd0, gnt[0]}, 16'd0);
        chkb("abort_done1", dn1[0], 1'b0);
        chk16("abort_hdr_checksum", hchk[0], 16'h0000);
        chk16("abort_hdr_id", hid[0], 16'h0000);
        chk16("abort_ip_id", ipid[0], 16'h0000);
        // Pointer was reset to "last served 0", so requester 1 wins this tie.
        txn(0, 1'b1, 1'b1, 16'h0011, 16'h0022, 16'h7E57, 2'b10, 1'b0);

        // req1 rising mid-grant is ignored until the next IDLE.
        rq0[0] = 1'b1; ln0[0] = 16'h0300; chk[0] = ~16'h2468;
        eg0.g = 2'b01; eg0.len = 16'h0300; eg0.chk = 16'h2468; eg0.id = m_id[0];
        sq0.push_back(eg0);
        @(negedge clk);
        chk16("glitch_calc_gnt", {14'd0, gnt[0]}, 16'd1);
        rq1[0] = 1'b1; ln1[0] = 16'h0444;
        @(negedge clk);
        chk16("glitch_wait_gnt", {14'd0, gnt[0]}, 16'd1);
        chk16("glitch_wait_len", tlen[0], 16'h0300);
        chk[0] = 16'h2468;
        @(negedge clk);
        chk16("glitch_done_gnt", {14'd0, gnt[0]}, 16'd1);
        rq0[0] = 1'b0; chk[0] = ~16'h2468;
        m_hdr[0] = 16'h2468; m_hid[0] = m_id[0]; m_id[0] = m_id[0] + 16'd1;
        @(negedge clk);
        txn(0, 1'b0, 1'b1, 16'h0000, 16'h0444, 16'hACE1, 2'b10, 1'b0);

        // Fixed-priority DUT: id wrap, then requester 1 starved by a held tie.
        txn(1, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1357, 2'b01, 1'b0);
        txn(1, 1'b1, 1'b1, 16'h0030, 16'h0031, 16'h1000, 2'b01, 1'b1);
        txn(1, 1'b1, 1'b1, 16'h0030, 16'h0031, 16'h2000, 2'b01, 1'b1);
        txn(1, 1'b1, 1'b1, 16'h0030, 16'h0031, 16'h3000, 2'b01, 1'b0);

        repeat (2) @(negedge clk);
        chk16("scoreboard_empty", 16'(sq0.size() + sq1.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
